// File: rtl/alu_muldiv_seq.sv
// Iterative SPARC V8 UMUL/SMUL/UDIV/SDIV (+cc) sequencer: 32 shift-add / restoring-divide steps.
// Latency: start in cycle 0 -> done in cycle 35; divide-by-zero / early overflow -> done in cycle 2.
// Backpressure: stall_out holds the pipeline from accept until FIX; a start outside IDLE is ignored.
module alu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [5:0]  op3,
    input  logic [31:0] valA,
    input  logic [31:0] valB,
    input  logic [31:0] Y_in,
    input  logic [3:0]  icc_in,
    output logic        stall_out,
    output logic        done,
    output logic [31:0] res_out,
    output logic [31:0] Y_out,
    output logic        Y_we,
    output logic [3:0]  icc_out,
    output logic        icc_we,
    output logic        div_zero
);
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] a_q, b_q, y_q, mb, mb_n;
    logic [3:0]  icc_q;
    logic        is_div_q, is_signed_q, is_cc_q;
    logic [63:0] acc, acc_n;
    logic        sign, sign_n;
    logic [4:0]  cnt, cnt_n;

    // op3 family: bit5=0, bit3=1, bit1=1; bit4 = cc, bit2 = divide, bit0 = signed
    logic supported, accept;
    assign supported = !op3[5] && op3[3] && op3[1];
    assign accept    = (state == IDLE) && start && supported && !flush;
    assign stall_out = accept || (state == PREP) || (state == RUN) || (state == FIX);

    // Magnitudes of the latched operands for the signed forms
    logic [63:0] dvd, dmag;
    logic [31:0] amag, bmag;
    assign dvd  = {y_q, a_q};
    assign dmag = y_q[31] ? (64'd0 - dvd) : dvd;
    assign amag = a_q[31] ? (32'd0 - a_q) : a_q;
    assign bmag = b_q[31] ? (32'd0 - b_q) : b_q;

    // One iteration step: multiply adds then shifts right, divide shifts left and trial-subtracts
    logic [32:0] mul_sum, div_top;
    logic [31:0] div_diff;
    logic        div_ge;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mb} : 33'd0);
    assign div_top  = acc[63:31];
    assign div_ge   = div_top >= {1'b0, mb};
    assign div_diff = div_top[31:0] - mb;

    logic [63:0] prod;
    logic [31:0] qmag;
    assign prod = sign ? (64'd0 - acc) : acc;
    assign qmag = acc[31:0];

    logic        load_out, out_dz, out_v;
    logic [31:0] out_res, out_y;

    // Next state, iteration datapath and the result to publish on entry to DONE
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mb_n     = mb;
        sign_n   = sign;
        cnt_n    = cnt;
        load_out = 1'b0;
        out_dz   = 1'b0;
        out_v    = 1'b0;
        out_res  = 32'd0;
        out_y    = y_q;
        case (state)
            IDLE: if (accept) state_n = PREP;
            PREP: begin
                if (is_div_q && b_q == 32'd0) begin
                    out_dz   = 1'b1;
                    load_out = 1'b1;
                    state_n  = DONE;
                end else if (is_div_q && !is_signed_q && y_q >= b_q) begin
                    out_res  = 32'hFFFF_FFFF;
                    out_v    = 1'b1;
                    load_out = 1'b1;
                    state_n  = DONE;
                end else if (is_div_q && is_signed_q && dmag[63:32] >= bmag) begin
                    out_res  = (y_q[31] ^ b_q[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    out_v    = 1'b1;
                    load_out = 1'b1;
                    state_n  = DONE;
                end else begin
                    if (is_div_q)
                        acc_n = is_signed_q ? dmag : dvd;
                    else
                        acc_n = {32'd0, is_signed_q ? amag : a_q};
                    mb_n    = is_signed_q ? bmag : b_q;
                    sign_n  = is_signed_q && ((is_div_q ? y_q[31] : a_q[31]) ^ b_q[31]);
                    cnt_n   = 5'd0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (is_div_q)
                    acc_n = {(div_ge ? div_diff : div_top[31:0]), acc[30:0], div_ge};
                else
                    acc_n = {mul_sum, acc[31:1]};
                cnt_n = cnt + 5'd1;
                if (cnt == 5'd31) state_n = FIX;
            end
            FIX: begin
                load_out = 1'b1;
                state_n  = DONE;
                if (!is_div_q) begin
                    out_res = prod[31:0];
                    out_y   = prod[63:32];
                end else if (is_signed_q && !sign && qmag > 32'h7FFF_FFFF) begin
                    out_res = 32'h7FFF_FFFF;
                    out_v   = 1'b1;
                end else if (is_signed_q && sign && qmag > 32'h8000_0000) begin
                    out_res = 32'h8000_0000;
                    out_v   = 1'b1;
                end else begin
                    out_res = sign ? (32'd0 - qmag) : qmag;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush && state != IDLE) begin
            state_n  = IDLE;
            load_out = 1'b0;
        end
    end

    // State, operand latches and iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            y_q         <= 32'd0;
            icc_q       <= 4'd0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            is_cc_q     <= 1'b0;
            acc         <= 64'd0;
            mb          <= 32'd0;
            sign        <= 1'b0;
            cnt         <= 5'd0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            mb    <= mb_n;
            sign  <= sign_n;
            cnt   <= cnt_n;
            if (accept) begin
                a_q         <= valA;
                b_q         <= valB;
                y_q         <= Y_in;
                icc_q       <= icc_in;
                is_div_q    <= op3[2];
                is_signed_q <= op3[0];
                is_cc_q     <= op3[4];
            end
        end
    end

    // Registered outputs: strobes pulse for one cycle, data holds until the next result
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            Y_we     <= 1'b0;
            icc_we   <= 1'b0;
            div_zero <= 1'b0;
            res_out  <= 32'd0;
            Y_out    <= 32'd0;
            icc_out  <= 4'd0;
        end else begin
            done     <= load_out;
            Y_we     <= load_out && !is_div_q;
            icc_we   <= load_out && is_cc_q && !out_dz;
            div_zero <= load_out && out_dz;
            if (load_out) begin
                res_out <= out_res;
                Y_out   <= out_y;
                icc_out <= (is_cc_q && !out_dz) ? {out_res[31], out_res == 32'd0, out_v, 1'b0} : icc_q;
            end
        end
    end
endmodule
